ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register for the MIPS32 core; successor to the plain EX/MEM latch.

---
 rtl/ex_mem_pipe_reg_if.sv | 35 +++
 rtl/ex_mem_pipe_reg.sv | 93 +++++++++
 tb/tb_ex_mem_pipe_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline bus: EX-side payload in, registered MEM-side payload and
// multicycle feedback (hilo_temp_o, cnt_o) out.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
);
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] ex_hilo_temp;
  logic [CNT_W-1:0]    ex_cnt;

  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with flush/stall bubble insertion, madd/msub
// multicycle state feedback and a saturating stall-bubble counter.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 3,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned PERF_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_pipe_reg_if.slave   bus,
  output logic [PERF_W-1:0]  bubble_cnt
);

  logic                stall_ex;
  logic                stall_mem;
  logic                unused_stall;

  logic [ADDR_W-1:0]   wd_q;
  logic                wreg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                whilo_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] temp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PERF_W-1:0]   bubble_q;

  assign stall_ex     = stall[STAGE_IDX];
  assign stall_mem    = stall[STAGE_IDX+1];
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= '0;
      whilo_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      temp_q   <= '0;
      cnt_q    <= '0;
      bubble_q <= '0;
    end else if (flush) begin
      // Squash wins over any stall; abandon the multicycle op too.
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      temp_q  <= '0;
      cnt_q   <= '0;
    end else if (stall_ex && !stall_mem) begin
      // MEM drains a bubble while EX keeps iterating its multicycle op.
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      temp_q  <= bus.ex_hilo_temp;
      cnt_q   <= bus.ex_cnt;
      if (bubble_q != {PERF_W{1'b1}}) begin
        bubble_q <= bubble_q + PERF_W'(1);
      end
    end else if (!stall_ex) begin
      wd_q    <= bus.ex_wd;
      wreg_q  <= bus.ex_wreg;
      wdata_q <= bus.ex_wdata;
      whilo_q <= bus.ex_whilo;
      hi_q    <= bus.ex_hi;
      lo_q    <= bus.ex_lo;
      temp_q  <= '0;
      cnt_q   <= '0;
    end
  end

  assign bus.mem_wd      = wd_q;
  assign bus.mem_wreg    = wreg_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_whilo   = whilo_q;
  assign bus.mem_hi      = hi_q;
  assign bus.mem_lo      = lo_q;
  assign bus.hilo_temp_o = temp_q;
  assign bus.cnt_o       = cnt_q;
  assign bubble_cnt      = bubble_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Table-driven bench for ex_mem_pipe_reg, plus a narrow-counter instance for
// bubble_cnt saturation and reset.
module tb_ex_mem_pipe_reg;

  localparam int unsigned CW = 185;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [63:0] e_temp;
    logic [1:0]  e_cnt;
    logic [15:0] e_bub;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int n_vec = 0;
  int n_err = 0;

  ex_mem_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) bus ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) bus2 ();

  assign bus2.ex_wd        = bus.ex_wd;
  assign bus2.ex_wreg      = bus.ex_wreg;
  assign bus2.ex_wdata     = bus.ex_wdata;
  assign bus2.ex_whilo     = bus.ex_whilo;
  assign bus2.ex_hi        = bus.ex_hi;
  assign bus2.ex_lo        = bus.ex_lo;
  assign bus2.ex_hilo_temp = bus.ex_hilo_temp;
  assign bus2.ex_cnt       = bus.ex_cnt;

  ex_mem_pipe_reg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus),
    .bubble_cnt (bubble_cnt)
  );

  ex_mem_pipe_reg #(.PERF_W(2)) dut_p2 (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus2),
    .bubble_cnt (bubble_cnt2)
  );

  always #5 clk = ~clk;

  // ctrl only ever emits monotone stall vectors.
  always @(posedge clk) begin
    assert (!(!stall[3] && stall[4])) else $error("illegal stall vector %b", stall);
  end

  task automatic check_all(input string name, input logic [CW-1:0] exp);
    logic [CW-1:0] act;
    act = {bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo, bus.mem_hi, bus.mem_lo,
           bus.hilo_temp_o, bus.cnt_o, bubble_cnt};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: bubble_cnt got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    stall            = v.stall;
    flush            = v.flush;
    bus.ex_wd        = v.wd;
    bus.ex_wreg      = v.wreg;
    bus.ex_wdata     = v.wdata;
    bus.ex_whilo     = v.whilo;
    bus.ex_hi        = v.hi;
    bus.ex_lo        = v.lo;
    bus.ex_hilo_temp = v.temp;
    bus.ex_cnt       = v.cnt;
  endtask

  vec_t vecs[13];

  initial begin
    // rst, stall, flush, wd, wreg, wdata, whilo, hi, lo, temp, cnt | expected outputs, bubble_cnt
    vecs[0]  = '{1'b1, 6'b000000, 1'b0, 5'd7, 1'b1, 32'h1234, 1'b1, 32'hAA, 32'hBB,
                 64'hFFFF, 2'd3, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0};
    vecs[1]  = '{1'b1, 6'b001111, 1'b0, 5'd7, 1'b1, 32'h1234, 1'b1, 32'hAA, 32'hBB,
                 64'hFFFF, 2'd3, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0};
    vecs[2]  = '{1'b0, 6'b000000, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0,
                 64'h55, 2'd2, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0};
    for (int i = 3; i < 6; i++) begin
      vecs[i] = '{1'b0, 6'b011111, 1'b0, 5'd9, 1'b0, 32'h1111, 1'b1, 32'h3, 32'h4,
                  64'h77, 2'd1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0};
    end
    vecs[6]  = '{1'b0, 6'b001111, 1'b0, 5'd9, 1'b1, 32'h1111, 1'b1, 32'h3, 32'h4,
                 64'h1_0000_0002, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                 64'h1_0000_0002, 2'd1, 16'd1};
    vecs[7]  = '{1'b0, 6'b000000, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h7,
                 64'h1_0000_0002, 2'd1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h7, 64'h0, 2'd0, 16'd1};
    vecs[8]  = '{1'b0, 6'b001111, 1'b0, 5'd4, 1'b1, 32'h2222, 1'b1, 32'h5, 32'h6,
                 64'hABCD, 2'd2, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'hABCD, 2'd2, 16'd2};
    vecs[9]  = '{1'b0, 6'b001111, 1'b1, 5'd3, 1'b1, 32'h3333, 1'b1, 32'h8, 32'h9,
                 64'h99, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd2};
    vecs[10] = '{1'b0, 6'b000000, 1'b0, 5'd12, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0,
                 64'h0, 2'd0, 5'd12, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd2};
    vecs[11] = '{1'b0, 6'b011111, 1'b1, 5'd12, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0,
                 64'h0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd2};
    vecs[12] = '{1'b0, 6'b000111, 1'b0, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h0,
                 64'h1, 2'd3, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h0, 64'h0, 2'd0,
                 16'd2};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i),
                {vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_wdata, vecs[i].e_whilo, vecs[i].e_hi,
                 vecs[i].e_lo, vecs[i].e_temp, vecs[i].e_cnt, vecs[i].e_bub});
      @(negedge clk);
    end

    // Counter saturation on the 2-bit instance versus free count on the 16-bit one.
    rst   = 1'b1;
    stall = 6'b000000;
    flush = 1'b0;
    @(posedge clk);
    #1;
    check_cnt("sat_rst_wide", bubble_cnt, 16'd0);
    check_cnt("sat_rst_narrow", {14'd0, bubble_cnt2}, 16'd0);
    @(negedge clk);
    rst   = 1'b0;
    stall = 6'b001111;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check_cnt($sformatf("sat_narrow%0d", i), {14'd0, bubble_cnt2},
                (i < 3) ? 16'(i) : 16'd3);
      check_cnt($sformatf("sat_wide%0d", i), bubble_cnt, 16'(i));
      @(negedge clk);
    end

    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cnt("midrun_rst_wide", bubble_cnt, 16'd0);
    check_cnt("midrun_rst_narrow", {14'd0, bubble_cnt2}, 16'd0);
    @(negedge clk);
    rst   = 1'b0;
    stall = 6'b011111;
    @(posedge clk);
    #1;
    check_cnt("hold_after_rst", {14'd0, bubble_cnt2}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
